// File: rtl/mpadder_seq_pkg.sv
// Shared encodings and defaults for the mpadder sequencing controller.
package mpadder_seq_pkg;

   typedef enum logic [1:0] {
      OP_ACCUM   = 2'b00,
      OP_SHIFT   = 2'b01,
      OP_RESOLVE = 2'b10,
      OP_REDUCE  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_SHIFT,
      S_RESOLVE,
      S_REDUCE,
      S_FINISH
   } state_e;

   // bit3 set makes mpadder hold its inter-chunk carry register
   localparam logic [3:0] CHUNK_IDLE = 4'hF;

   localparam int NUM_CHUNKS_DEF     = 5;
   localparam int MAX_SUB_PASSES_DEF = 4;

   function automatic state_e op2state(input op_e op);
      case (op)
         OP_ACCUM:   return S_ACCUM;
         OP_SHIFT:   return S_SHIFT;
         OP_RESOLVE: return S_RESOLVE;
         default:    return S_REDUCE;
      endcase
   endfunction

endpackage

// File: rtl/mpadder_chunk_seq.sv
// Wrapping chunk-index counter; parks at CHUNK_IDLE whenever not started or advanced.
module mpadder_chunk_seq
   import mpadder_seq_pkg::*;
#(
   parameter int NUM_CHUNKS = NUM_CHUNKS_DEF,
   parameter int SEL_W      = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             en,
   output logic [SEL_W-1:0] chunk_sel,
   output logic             last
);

   localparam logic [SEL_W-1:0] IDLE_SEL = SEL_W'(CHUNK_IDLE);
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CHUNKS - 1);

   assign last = (chunk_sel == LAST_SEL);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         chunk_sel <= IDLE_SEL;
      else if (start)
         chunk_sel <= '0;
      else if (en)
         chunk_sel <= last ? '0 : chunk_sel + 1'b1;
      else
         chunk_sel <= IDLE_SEL;
   end

endmodule

// File: rtl/mpadder_seq_ctrl.sv
// Command sequencer driving mpadder control pins for ACCUM/SHIFT/RESOLVE/REDUCE.
// Optional MPADDER_SEQ_PERF_EN adds perf_cycles (acceptance-to-done cycle count).
module mpadder_seq_ctrl
   import mpadder_seq_pkg::*;
#(
   parameter int NUM_CHUNKS     = NUM_CHUNKS_DEF,
   parameter int MAX_SUB_PASSES = MAX_SUB_PASSES_DEF,
   parameter int SEL_W          = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   output logic             done,
   output logic             err,
   output logic             add_enable_c,
   output logic             add_shift,
   output logic             add_subtract,
   output logic [SEL_W-1:0] add_chunk_sel,
   input  logic             add_sub_finished,
   output logic [2:0]       pass_cnt
`ifdef MPADDER_SEQ_PERF_EN
   ,output logic [15:0]     perf_cycles
`endif
);

   localparam logic [2:0]       MAX_P      = 3'(MAX_SUB_PASSES);
   localparam logic [SEL_W-1:0] PRELAST_SEL = SEL_W'(NUM_CHUNKS - 2);

   state_e state, state_nxt;
   logic   chunk_start, chunk_en, chunk_last, err_set;
   logic   accept, pass_inc;

   assign accept   = (state == S_IDLE) && cmd_valid;
   // next cycle is a chunk-4 cycle, so the pass count lands together with it
   assign pass_inc = (state == S_REDUCE) && (add_chunk_sel == PRELAST_SEL);

   mpadder_chunk_seq #(
      .NUM_CHUNKS (NUM_CHUNKS),
      .SEL_W      (SEL_W)
   ) u_chunk (
      .clk       (clk),
      .resetn    (resetn),
      .start     (chunk_start),
      .en        (chunk_en),
      .chunk_sel (add_chunk_sel),
      .last      (chunk_last)
   );

   // cmd_op is captured on acceptance by encoding it into the next state
   always_comb begin
      state_nxt   = state;
      chunk_start = 1'b0;
      chunk_en    = 1'b0;
      err_set     = 1'b0;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               state_nxt   = op2state(op_e'(cmd_op));
               chunk_start = (cmd_op == OP_RESOLVE) || (cmd_op == OP_REDUCE);
            end
         end
         S_ACCUM, S_SHIFT: state_nxt = S_FINISH;
         S_RESOLVE: begin
            if (chunk_last) state_nxt = S_FINISH;
            else            chunk_en  = 1'b1;
         end
         S_REDUCE: begin
            if (!chunk_last)
               chunk_en = 1'b1;
            else if (add_sub_finished)
               state_nxt = S_FINISH;
            else if (pass_cnt >= MAX_P) begin
               state_nxt = S_FINISH;
               err_set   = 1'b1;
            end else
               chunk_en = 1'b1;
         end
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= S_IDLE;
         cmd_ready    <= 1'b1;
         done         <= 1'b0;
         err          <= 1'b0;
         add_enable_c <= 1'b0;
         add_shift    <= 1'b0;
         add_subtract <= 1'b0;
         pass_cnt     <= '0;
      end else begin
         state        <= state_nxt;
         cmd_ready    <= (state_nxt == S_IDLE);
         done         <= (state_nxt == S_FINISH);
         add_enable_c <= (state_nxt == S_ACCUM);
         add_shift    <= (state_nxt == S_SHIFT);
         add_subtract <= (state_nxt == S_REDUCE);
         if (accept)       err <= 1'b0;
         else if (err_set) err <= 1'b1;
         if (accept && (cmd_op == OP_REDUCE)) pass_cnt <= '0;
         else if (pass_inc)                  pass_cnt <= pass_cnt + 1'b1;
      end
   end

`ifdef MPADDER_SEQ_PERF_EN
   // cyc_cnt includes the acceptance cycle; +2 covers the current and FINISH cycles
   logic [15:0] cyc_cnt;
   logic [16:0] perf_sum;

   assign perf_sum = {1'b0, cyc_cnt} + 17'd2;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cyc_cnt     <= '0;
         perf_cycles <= '0;
      end else begin
         if (accept)
            cyc_cnt <= 16'd1;
         else if ((state != S_IDLE) && (cyc_cnt != 16'hFFFF))
            cyc_cnt <= cyc_cnt + 16'd1;
         if ((state_nxt == S_FINISH) && (state != S_FINISH))
            perf_cycles <= perf_sum[16] ? 16'hFFFF : perf_sum[15:0];
      end
   end
`endif

endmodule

// File: tb/tb_mpadder_seq_ctrl.sv
// Self-checking bench: command table, scoreboard queue, per-cycle monitor and sub_finished responder.
module tb_mpadder_seq_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic       done, err;
   logic       add_enable_c, add_shift, add_subtract;
   logic [3:0] add_chunk_sel;
   logic       add_sub_finished;
   logic [2:0] pass_cnt;
`ifdef MPADDER_SEQ_PERF_EN
   logic [15:0] perf_cycles;
`endif

   always #5 clk = ~clk;

   mpadder_seq_ctrl dut (
      .clk              (clk),
      .resetn           (resetn),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_op           (cmd_op),
      .done             (done),
      .err              (err),
      .add_enable_c     (add_enable_c),
      .add_shift        (add_shift),
      .add_subtract     (add_subtract),
      .add_chunk_sel    (add_chunk_sel),
      .add_sub_finished (add_sub_finished),
      .pass_cnt         (pass_cnt)
`ifdef MPADDER_SEQ_PERF_EN
      ,.perf_cycles     (perf_cycles)
`endif
   );

   // fin: chunk-4 pass on which add_sub_finished is returned (0 = never)
   typedef struct {
      int         id;
      logic [1:0] op;
      int         fin;
      int         lat;
      int         n_en;
      int         n_sh;
      int         n_sub;
      int         pass;
      int         err;
      bit         scr;
   } vec_t;

   vec_t tbl[10];
   vec_t exp_q[$];
   vec_t cur;

   int n_chk = 0, n_fail = 0;
   int done_seen = 0, mutex_bad = 0;
   bit busy = 0, post = 0;
   int cyc, rpass, c_en, c_sh, c_sub, ch_bad;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic issue(input vec_t v);
      int n = 0;
      exp_q.push_back(v);
      cmd_valid = 1'b1;
      while (!cmd_ready) begin
         cmd_op = v.scr ? 2'($urandom) : v.op;
         @(posedge clk); #1;
         if (++n > 200) begin
            chk($sformatf("v%0d_accept_timeout", v.id), 0, 1);
            break;
         end
      end
      cmd_op = v.op;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
   endtask

   // monitor + responder, all sampling on the falling edge
   initial begin
      int exp_ch;
      add_sub_finished = 1'b0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            if (busy && exp_q.size() > 0) void'(exp_q.pop_front());
            busy = 0;
            post = 0;
            continue;
         end
         if (int'(add_enable_c) + int'(add_shift) + int'(add_subtract) > 1) mutex_bad++;
         if (done) done_seen++;
         if (post) begin
            chk($sformatf("v%0d_ready_after_done", cur.id), int'(cmd_ready), 1);
            post = 0;
         end
         if (busy) begin
            cyc++;
            if (cyc == 1) chk($sformatf("v%0d_err_cleared", cur.id), int'(err), 0);
            if (cur.op[1] && cyc < cur.lat) exp_ch = (cyc - 1) % 5;
            else                            exp_ch = 15;
            if (int'(add_chunk_sel) != exp_ch) ch_bad++;
            c_en  += int'(add_enable_c);
            c_sh  += int'(add_shift);
            c_sub += int'(add_subtract);
            if (done) begin
               chk($sformatf("v%0d_latency", cur.id), cyc, cur.lat);
               chk($sformatf("v%0d_enable_c_cycles", cur.id), c_en, cur.n_en);
               chk($sformatf("v%0d_shift_cycles", cur.id), c_sh, cur.n_sh);
               chk($sformatf("v%0d_subtract_cycles", cur.id), c_sub, cur.n_sub);
               chk($sformatf("v%0d_chunk_seq_errs", cur.id), ch_bad, 0);
               chk($sformatf("v%0d_pass_cnt", cur.id), int'(pass_cnt), cur.pass);
               chk($sformatf("v%0d_err", cur.id), int'(err), cur.err);
               chk($sformatf("v%0d_ready_at_done", cur.id), int'(cmd_ready), 0);
`ifdef MPADDER_SEQ_PERF_EN
               chk($sformatf("v%0d_perf_cycles", cur.id), int'(perf_cycles), cur.lat + 1);
`endif
               void'(exp_q.pop_front());
               busy = 0;
               post = 1;
            end else if (cyc > 60) begin
               chk($sformatf("v%0d_done_timeout", cur.id), 0, 1);
               void'(exp_q.pop_front());
               busy = 0;
            end
         end
         // asserted everywhere except a chunk-4 subtract cycle, where it means "finished"
         if (add_subtract && add_chunk_sel == 4'd4) begin
            rpass++;
            add_sub_finished = busy && (rpass == cur.fin);
         end else
            add_sub_finished = 1'b1;
         if (cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0)
               chk("unexpected_accept", 1, 0);
            else begin
               cur = exp_q[0];
               busy = 1;
               cyc = 0; rpass = 0;
               c_en = 0; c_sh = 0; c_sub = 0; ch_bad = 0;
            end
         end
      end
   end

   initial begin
      int n;
      //          id op     fin lat en sh sub pass err scr
      tbl[0] = '{0, 2'b00, 0,  2, 1, 0, 0,  0,  0, 0};
      tbl[1] = '{1, 2'b01, 0,  2, 0, 1, 0,  0,  0, 0};
      tbl[2] = '{2, 2'b10, 0,  6, 0, 0, 0,  0,  0, 0};
      tbl[3] = '{3, 2'b11, 2, 11, 0, 0, 10, 2,  0, 0};
      tbl[4] = '{4, 2'b11, 0, 21, 0, 0, 20, 4,  1, 0};
      tbl[5] = '{5, 2'b00, 0,  2, 1, 0, 0,  4,  0, 1};
      tbl[6] = '{6, 2'b11, 1,  6, 0, 0, 5,  1,  0, 0};
      tbl[7] = '{7, 2'b11, 4, 21, 0, 0, 20, 4,  0, 1};
      tbl[8] = '{8, 2'b10, 0,  6, 0, 0, 0,  4,  0, 1};
      tbl[9] = '{9, 2'b01, 0,  2, 0, 1, 0,  4,  0, 0};

      resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_ctrl_pins", int'({add_enable_c, add_shift, add_subtract}), 0);
      chk("rst_chunk_sel", int'(add_chunk_sel), 15);
      chk("rst_pass_cnt", int'(pass_cnt), 0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // abort RESOLVE at chunk 2 with a one-cycle asynchronous reset
      issue('{99, 2'b10, 0, 6, 0, 0, 0, 0, 0, 0});
      n = 0;
      while (add_chunk_sel != 4'd2 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("midrst_reached_chunk2", int'(add_chunk_sel), 2);
      #2 resetn = 1'b0;
      #1;
      chk("midrst_async_ready", int'(cmd_ready), 1);
      chk("midrst_async_chunk", int'(add_chunk_sel), 15);
      chk("midrst_async_done", int'(done), 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      chk("midrst_ready_after", int'(cmd_ready), 1);
      chk("midrst_no_done", done_seen, 0);

      for (int i = 0; i < 10; i++) issue(tbl[i]);

      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("queue_drained", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("done_pulse_count", done_seen, 10);
      chk("ctrl_mutex_violations", mutex_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mpadder_seq_ctrl.md
Name: mpadder_seq_ctrl

Overview:
Sequencing controller for the 514-bit carry-save multi-precision adder (mpadder). It accepts one command at a time over a valid/ready handshake and drives the adder control pins (enableC, shift, subtract, chunk select) cycle by cycle. It runs the 5-chunk carry-propagate resolve and the iterated conditional-subtract reduction. It reports completion, or an error if the iteration bound is exceeded. It sits between the Montgomery top-level FSM and mpadder.

Parameters:
NUM_CHUNKS, 5, number of chunk-select steps per pass (chunk indices 0..NUM_CHUNKS-1)
MAX_SUB_PASSES, 4, maximum subtract passes before err
SEL_W, 4, width of chunk-select bus

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  controller idle, command accepted when valid&ready
cmd_op  in  2  00 ACCUM, 01 SHIFT, 10 RESOLVE, 11 REDUCE
done  out  1  one-cycle pulse on command completion
err  out  1  sticky; REDUCE exceeded MAX_SUB_PASSES; cleared on next accepted command
add_enable_c  out  1  to mpadder enableC
add_shift  out  1  to mpadder shift
add_subtract  out  1  to mpadder subtract
add_chunk_sel  out  SEL_W  to mpadder chunk index (showFluffyPonies)
add_sub_finished  in  1  from mpadder carry (subtract finished)
pass_cnt  out  3  number of subtract passes used by last REDUCE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on resetn.
- Reset values: state IDLE, cmd_ready=1, done=0, err=0, add_enable_c=0, add_shift=0, add_subtract=0, add_chunk_sel=4'hF (CHUNK_IDLE), pass_cnt=0.
- All outputs are registered and decoded from the next state.
- Reset asserted mid-operation aborts immediately to reset values. No partial done is issued.
- CHUNK_IDLE=4'hF has bit3 set, so mpadder holds its inter-chunk carry register. add_chunk_sel is CHUNK_IDLE in every state except RESOLVE and REDUCE.
- States: IDLE, ACCUM, SHIFT, RESOLVE, REDUCE, FINISH.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_op, clear err, and go to the op state on the next edge.
  - cmd_op is sampled only on acceptance.
- ACCUM: one cycle with add_enable_c=1, then FINISH.
- SHIFT: one cycle with add_shift=1, then FINISH.
- RESOLVE:
  - NUM_CHUNKS cycles with add_subtract=0 and add_chunk_sel=0,1,2,3,4 in consecutive cycles, then FINISH.
  - Latency from acceptance to done is 7 cycles.
- REDUCE:
  - add_subtract=1 throughout, and add_chunk_sel cycles 0..4 repeatedly.
  - pass_cnt increments on each chunk-4 cycle.
  - On a chunk-4 cycle with add_sub_finished=1, go to FINISH.
  - Else, if pass_cnt has reached MAX_SUB_PASSES, set err=1 and go to FINISH.
  - Else start the next pass at chunk 0, with no bubble between passes.
- FINISH:
  - done=1 for one cycle; all adder controls are idle; return to IDLE.
  - cmd_ready=0 here, so back-to-back commands are spaced by one idle cycle.
- Mutual exclusion: at most one of add_enable_c, add_shift, add_subtract is high in any cycle. The bench asserts this.
- add_sub_finished is ignored outside REDUCE chunk-4 cycles.
- cmd_valid while busy is ignored (no queueing); the requester holds cmd_valid until accepted.

Optional Feature:
MPADDER_SEQ_PERF_EN
- Defined: adds output perf_cycles[15:0], which counts cycles from acceptance to done of the last command. It saturates at 16'hFFFF, resets to 0, and is updated at FINISH.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mpadder_seq_pkg holds:
  - op encodings (OP_ACCUM, OP_SHIFT, OP_RESOLVE, OP_REDUCE);
  - the state enum;
  - CHUNK_IDLE=4'hF;
  - default NUM_CHUNKS and MAX_SUB_PASSES.
- One sub-module, mpadder_chunk_seq: a wrapping 0..NUM_CHUNKS-1 counter with start, enable, last-chunk flag and idle output CHUNK_IDLE. The FSM reuses it for RESOLVE and REDUCE.

Test Plan:
- Reset mid-RESOLVE, at chunk 2, by resetn low for 1 cycle -> outputs return to reset values asynchronously; no done; cmd_ready=1 after release.
- ACCUM accepted at cycle 0 -> add_enable_c=1 at cycle 1 only; done at cycle 2; cmd_ready=1 at cycle 3.
- SHIFT then RESOLVE back-to-back -> add_shift single pulse; RESOLVE shows chunk_sel 0,1,2,3,4 then 4'hF; add_subtract=0 throughout; done once per command.
- REDUCE with add_sub_finished=1 on the second chunk-4 cycle -> 10 cycles of add_subtract=1; pass_cnt=2; err=0; done pulse.
- REDUCE with add_sub_finished never asserted -> exactly 4 passes (20 cycles); err=1 with done; err clears on next accepted ACCUM.
- cmd_valid held high with a changing cmd_op during REDUCE -> ignored until the next IDLE. With MPADDER_SEQ_PERF_EN: RESOLVE gives perf_cycles=7.
